mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester and the data load/store requester.
- Sits between the CPU (datapath/control) and the single memory or cache port.
- Uses the existing read/write + resp handshake: requesters hold read/write until a one-cycle resp pulse.
- Data has priority. A streak limit guarantees instruction forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, number of consecutive data grants allowed while an instruction request waits; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on posedge clk)
- i_read  in  1  instruction read request
- i_address  in  ADDR_W  instruction address
- i_resp  out  1  instruction response pulse
- i_rdata  out  DATA_W  instruction read data
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_byte_enable  in  DATA_W/8  write byte mask
- d_resp  out  1  data response pulse
- d_rdata  out  DATA_W  data read data
- pmem_read  out  1  downstream read
- pmem_write  out  1  downstream write
- pmem_address  out  ADDR_W  downstream address
- pmem_wdata  out  DATA_W  downstream write data
- pmem_byte_enable  out  DATA_W/8  downstream mask
- pmem_resp  in  1  downstream response pulse
- pmem_rdata  in  DATA_W  downstream read data
- protocol_err  out  1  one-cycle pulse when d_read and d_write are both high at grant

Behaviour:
- State machine states: IDLE, SERVE_I, SERVE_D. Reset places the FSM in IDLE.
- Reset values: all outputs 0, streak counter 0, latched request registers 0.
- IDLE arbitration, evaluated each cycle:
  - Pending requests are i_pend = i_read and d_pend = d_read|d_write.
  - Only d_pend: go to SERVE_D.
  - Only i_pend: go to SERVE_I.
  - Both pending and streak < MAX_D_STREAK: go to SERVE_D.
  - Both pending and streak == MAX_D_STREAK: go to SERVE_I.
  - Neither pending: stay in IDLE.
- Grant latch: on the IDLE->SERVE_* edge, the arbiter latches address, wdata, byte_enable and the op (read/write).
  - The pmem_* outputs are driven only from these latched copies.
  - A requester changing or dropping its inputs mid-service has no effect.
- Instruction grants always issue a read; pmem_byte_enable is forced to all-ones.
- Data grant with both d_read and d_write high: the arbiter issues a write and pulses protocol_err in the first SERVE_D cycle.
- Latency: a request seen in IDLE at cycle N produces pmem_read/pmem_write high from cycle N+1.
- While in SERVE_*:
  - pmem_read/pmem_write are held until pmem_resp.
  - pmem_resp is combinationally forwarded to the granted requester's resp in the same cycle.
  - pmem_rdata is combinationally forwarded to i_rdata/d_rdata, valid only while the matching resp is high; otherwise the rdata outputs are 0.
- The cycle in which pmem_resp is high:
  - pmem_read/pmem_write remain asserted during that cycle.
  - The next state is IDLE unconditionally, giving one bubble cycle.
  - The earliest next grant is at M+2 for a response at M. This guarantees the just-served requester has deasserted before re-arbitration.
- Streak counter, width clog2(MAX_D_STREAK+1), updated at the grant edge:
  - Data grant while i_pend: increment, saturating.
  - Data grant without i_pend: clear.
  - Instruction grant: clear.
- pmem_resp while in IDLE (stale or spurious) is ignored and not forwarded.
- Reset asserted mid-transaction: the next cycle is IDLE with pmem_read/pmem_write=0; any later pmem_resp for the aborted access is ignored.
- Reset has priority over all other events.
- Requests are never dropped: a non-granted requester simply waits with its request held.

Decomposition:
- Add the arbiter state enum (arb_state_t: IDLE, SERVE_I, SERVE_D) to rv32i_types as a shared typedef so that RVFI/monitor code can decode it.
- The latched request bundle uses a packed struct arb_req_t {addr, wdata, be, we} in the same package.
- No sub-module. The FSM, latch and counter form one module (~150-250 lines).

Test Plan:
- Lone instruction read: i_read=1 with i_address=0x60, memory responds 3 cycles later with 0x00000013 -> pmem_read=1, pmem_address=0x60 from the cycle after the request; i_resp=1 and i_rdata=0x13 in the resp cycle; d_resp stays 0.
- Contention: i_read and d_write (addr 0x100, wdata 0xDEADBEEF, be 0b0011) both asserted -> write served first with pmem_byte_enable=0b0011; after resp, one IDLE cycle, then pmem_read at 0x60.
- Starvation: i_read held while d_read is re-asserted continuously, MAX_D_STREAK=4 -> exactly 4 data grants, then an instruction grant, then the counter is cleared.
- Stability: d_address changes from 0x100 to 0x200 during SERVE_D -> pmem_address stays 0x100 until resp.
- Reset mid-op: rst=0 during SERVE_D, then pmem_resp pulses after release -> all outputs 0, d_resp never asserted, FSM in IDLE.
- Protocol error: d_read=d_write=1 -> pmem_write=1, pmem_read=0, and a single-cycle protocol_err pulse.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared CPU types: arbiter state and the latched memory request bundle.
package rv32i_types;

   localparam int unsigned ArbAddrW = 32;
   localparam int unsigned ArbDataW = 32;
   localparam int unsigned ArbBeW   = ArbDataW / 8;

   typedef enum logic [1:0] {
      StIdle,
      StServeI,
      StServeD
   } arb_state_t;

   typedef struct packed {
      logic [ArbAddrW-1:0] addr;
      logic [ArbDataW-1:0] wdata;
      logic [ArbBeW-1:0]   be;
      logic                we;
   } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data wins ties, bounded by a streak limit so fetch always makes progress.
module mem_port_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned ADDR_W       = ArbAddrW,
   parameter int unsigned DATA_W       = ArbDataW,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic                i_resp,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byte_enable,
   output logic                d_resp,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [ADDR_W-1:0]   pmem_address,
   output logic [DATA_W-1:0]   pmem_wdata,
   output logic [DATA_W/8-1:0] pmem_byte_enable,
   input  logic                pmem_resp,
   input  logic [DATA_W-1:0]   pmem_rdata,
   output logic                protocol_err
);

   localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

   arb_state_t         state_q, state_d;
   arb_req_t           req_q, req_d;
   logic [StreakW-1:0] streak_q, streak_d;
   logic               err_q, err_d;
   logic               i_pend, d_pend;

   assign i_pend = i_read;
   assign d_pend = d_read | d_write;

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      streak_d = streak_q;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (d_pend && (!i_pend || (streak_q < StreakMax))) begin
               state_d     = StServeD;
               req_d.addr  = ArbAddrW'(d_address);
               req_d.wdata = ArbDataW'(d_wdata);
               req_d.be    = ArbBeW'(d_byte_enable);
               // A read+write collision resolves to the write.
               req_d.we    = d_write;
               err_d       = d_read & d_write;
               if (!i_pend) begin
                  streak_d = '0;
               end else if (streak_q != StreakMax) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (i_pend) begin
               state_d     = StServeI;
               req_d.addr  = ArbAddrW'(i_address);
               req_d.wdata = '0;
               req_d.be    = '1;
               req_d.we    = 1'b0;
               streak_d    = '0;
            end
         end
         StServeI, StServeD: begin
            // Always drop back to idle: the bubble lets the served side deassert.
            if (pmem_resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         req_q    <= '0;
         streak_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         streak_q <= streak_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      i_rdata    = '0;
      d_rdata    = '0;
      unique case (state_q)
         StServeI: begin
            pmem_read = 1'b1;
            i_resp    = pmem_resp;
            if (pmem_resp) i_rdata = pmem_rdata;
         end
         StServeD: begin
            pmem_read  = ~req_q.we;
            pmem_write = req_q.we;
            d_resp     = pmem_resp;
            if (pmem_resp) d_rdata = pmem_rdata;
         end
         default: ;
      endcase
   end

   assign pmem_address     = ADDR_W'(req_q.addr);
   assign pmem_wdata       = DATA_W'(req_q.wdata);
   assign pmem_byte_enable = (DATA_W / 8)'(req_q.be);
   assign protocol_err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   localparam int unsigned MAX = 4;

   typedef struct packed {
      logic        is_i;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read, d_read, d_write, pmem_resp;
   logic [31:0] i_address, d_address, d_wdata, pmem_rdata;
   logic [3:0]  d_byte_enable;
   logic        i_resp, d_resp, pmem_read, pmem_write, protocol_err;
   logic [31:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
   logic [3:0]  pmem_byte_enable;

   int          vectors = 0;
   int          miscompares = 0;

   // Round description filled in by each scenario before calling test_round.
   txn_t        d_list [8];
   int          d_cnt;
   bit          use_i;
   logic [31:0] i_addr_r;
   logic [31:0] scram;
   int          fixed_lat;
   bit          fixed_rd_en;
   logic [31:0] fixed_rd;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_D_STREAK(MAX)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_read          (i_read),
      .i_address       (i_address),
      .i_resp          (i_resp),
      .i_rdata         (i_rdata),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_byte_enable   (d_byte_enable),
      .d_resp          (d_resp),
      .d_rdata         (d_rdata),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_byte_enable(pmem_byte_enable),
      .pmem_resp       (pmem_resp),
      .pmem_rdata      (pmem_rdata),
      .protocol_err    (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic present_d(input int idx);
      if (idx < d_cnt) begin
         d_read        = ~d_list[idx].we;
         d_write       = d_list[idx].we;
         d_address     = d_list[idx].addr;
         d_wdata       = d_list[idx].wdata;
         d_byte_enable = d_list[idx].be;
      end else begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; i_read = 1'b1; d_read = 1'b0; d_write = 1'b1;
      i_address = 32'h44; d_address = 32'h88; d_wdata = 32'hFFFF_FFFF; d_byte_enable = 4'hF;
      pmem_resp = 1'b1; pmem_rdata = 32'hA5A5_A5A5;
      repeat (2) @(negedge clk);
      vectors++;
      if ({i_resp, d_resp, pmem_read, pmem_write, protocol_err, i_rdata, d_rdata, pmem_address,
           pmem_wdata, pmem_byte_enable} !== '0) begin
         miscompares++;
         $display("FAIL reset: outputs rd=%b wr=%b resp=%b%b addr=%h wdata=%h be=%h, want all 0",
                  pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata, pmem_byte_enable);
      end
      i_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0; rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release: rd=%b wr=%b, want 0 0", pmem_read, pmem_write);
      end
   endtask

   // One arbitration round: optional fetch plus a back-to-back data stream.
   task automatic test_round(input string name);
      txn_t        exp_q [$];
      txn_t        e;
      int          n_d, lat, dp;
      logic [31:0] rd;
      n_d = (use_i && d_cnt > MAX) ? MAX : d_cnt;
      for (int k = 0; k < n_d; k++) exp_q.push_back(d_list[k]);
      if (use_i) begin
         e = '0; e.is_i = 1'b1; e.addr = i_addr_r; e.be = 4'hF;
         exp_q.push_back(e);
      end
      for (int k = n_d; k < d_cnt; k++) exp_q.push_back(d_list[k]);
      dp = 0;
      @(negedge clk);
      i_read = use_i; i_address = i_addr_r;
      present_d(dp);
      foreach (exp_q[g]) begin
         e = exp_q[g];
         @(negedge clk);
         vectors++;
         if ({pmem_read, pmem_write, pmem_address, pmem_byte_enable, protocol_err} !==
             {~e.we, e.we, e.addr, e.be, 1'b0}) begin
            miscompares++;
            $display("FAIL %s grant%0d: got rd=%b wr=%b addr=%h be=%h err=%b, want rd=%b wr=%b addr=%h be=%h err=0",
                     name, g, pmem_read, pmem_write, pmem_address, pmem_byte_enable, protocol_err,
                     ~e.we, e.we, e.addr, e.be);
         end
         if (e.we) begin
            vectors++;
            if (pmem_wdata !== e.wdata) begin
               miscompares++;
               $display("FAIL %s wdata%0d: got %h want %h", name, g, pmem_wdata, e.wdata);
            end
         end
         lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
         for (int c = 1; c < lat; c++) begin
            i_address = i_addr_r ^ scram;
            if (dp < d_cnt) begin
               d_address = d_list[dp].addr ^ scram;
               d_wdata   = ~d_list[dp].wdata;
            end
            @(negedge clk);
            vectors++;
            if ({pmem_read, pmem_write, pmem_address} !== {~e.we, e.we, e.addr}) begin
               miscompares++;
               $display("FAIL %s hold%0d: got rd=%b wr=%b addr=%h, want rd=%b wr=%b addr=%h",
                        name, g, pmem_read, pmem_write, pmem_address, ~e.we, e.we, e.addr);
            end
         end
         rd = fixed_rd_en ? fixed_rd : $urandom;
         pmem_resp = 1'b1; pmem_rdata = rd;
         #1;
         vectors++;
         if ({i_resp, d_resp, i_rdata, d_rdata} !==
             {e.is_i, ~e.is_i, (e.is_i ? rd : 32'h0), (e.is_i ? 32'h0 : rd)}) begin
            miscompares++;
            $display("FAIL %s resp%0d: got i=%b/%h d=%b/%h, want i=%b d=%b data %h",
                     name, g, i_resp, i_rdata, d_resp, d_rdata, e.is_i, ~e.is_i, rd);
         end
         @(negedge clk);
         pmem_resp = 1'b0; pmem_rdata = '0;
         i_address = i_addr_r;
         if (e.is_i) i_read = 1'b0;
         else dp++;
         present_d(dp);
         vectors++;
         if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s bubble%0d: got rd=%b wr=%b i_resp=%b d_resp=%b, want all 0",
                     name, g, pmem_read, pmem_write, i_resp, d_resp);
         end
         // A response while idle must not reach either requester.
         pmem_resp = 1'b1; pmem_rdata = $urandom;
         #1;
         vectors++;
         if ({i_resp, d_resp, i_rdata, d_rdata} !== '0) begin
            miscompares++;
            $display("FAIL %s idle_resp%0d: got i=%b/%h d=%b/%h, want 0", name, g, i_resp, i_rdata,
                     d_resp, d_rdata);
         end
         #1;
         pmem_resp = 1'b0; pmem_rdata = '0;
      end
   endtask

   task automatic defaults();
      d_cnt = 0; use_i = 1'b0; i_addr_r = 32'h60; scram = '0;
      fixed_lat = 0; fixed_rd_en = 1'b0; fixed_rd = '0;
   endtask

   task automatic test_lone_ifetch();
      defaults();
      use_i = 1'b1; fixed_lat = 3; fixed_rd_en = 1'b1; fixed_rd = 32'h0000_0013;
      test_round("lone_ifetch");
   endtask

   task automatic test_starvation();
      defaults();
      use_i = 1'b1; d_cnt = 6;
      for (int k = 0; k < 6; k++) d_list[k] = {1'b0, 1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF};
      test_round("starve6");
      d_cnt = 4;
      test_round("starve4");
   endtask

   task automatic test_contention();
      defaults();
      use_i = 1'b1; d_cnt = 1; fixed_lat = 2;
      d_list[0] = {1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011};
      test_round("contention");
   endtask

   task automatic test_stability();
      defaults();
      d_cnt = 1; fixed_lat = 3; scram = 32'h300;
      d_list[0] = {1'b0, 1'b0, 32'h100, 32'h0, 4'hF};
      test_round("stability");
   endtask

   task automatic test_protocol_err();
      @(negedge clk);
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h180; d_wdata = 32'h1234_5678;
      d_byte_enable = 4'b1010;
      @(negedge clk);
      vectors++;
      if ({pmem_write, pmem_read, protocol_err, pmem_address, pmem_wdata} !==
          {1'b1, 1'b0, 1'b1, 32'h180, 32'h1234_5678}) begin
         miscompares++;
         $display("FAIL proto_grant: got wr=%b rd=%b err=%b addr=%h wdata=%h, want 1 0 1 180 12345678",
                  pmem_write, pmem_read, protocol_err, pmem_address, pmem_wdata);
      end
      @(negedge clk);
      vectors++;
      if ({pmem_write, protocol_err} !== 2'b10) begin
         miscompares++;
         $display("FAIL proto_pulse: got wr=%b err=%b, want wr=1 err=0", pmem_write, protocol_err);
      end
      pmem_resp = 1'b1;
      #1;
      vectors++;
      if (d_resp !== 1'b1) begin
         miscompares++;
         $display("FAIL proto_resp: got d_resp=%b want 1", d_resp);
      end
      @(negedge clk);
      pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
      vectors++;
      if ({pmem_write, protocol_err} !== 2'b00) begin
         miscompares++;
         $display("FAIL proto_end: got wr=%b err=%b, want 0 0", pmem_write, protocol_err);
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h140; d_wdata = 32'hCAFE_F00D; d_byte_enable = 4'hF;
      @(negedge clk);
      vectors++;
      if (pmem_write !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_grant: got wr=%b want 1", pmem_write);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({pmem_read, pmem_write, d_resp, i_resp, protocol_err, pmem_address} !== '0) begin
         miscompares++;
         $display("FAIL midrst_clear: got rd=%b wr=%b d_resp=%b addr=%h, want all 0",
                  pmem_read, pmem_write, d_resp, pmem_address);
      end
      rst = 1'b1; d_write = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b1; pmem_rdata = 32'h7777_7777;
      #1;
      vectors++;
      if ({d_resp, i_resp, d_rdata, i_rdata} !== '0) begin
         miscompares++;
         $display("FAIL midrst_stale: got d_resp=%b d_rdata=%h i_resp=%b, want 0", d_resp, d_rdata,
                  i_resp);
      end
      @(negedge clk);
      pmem_resp = 1'b0; pmem_rdata = '0;
      vectors++;
      if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin
         miscompares++;
         $display("FAIL midrst_idle: got rd=%b wr=%b d_resp=%b, want 0 0 0", pmem_read, pmem_write,
                  d_resp);
      end
   endtask

   task automatic test_random(input int rounds);
      for (int r = 0; r < rounds; r++) begin
         defaults();
         use_i    = 1'($urandom);
         d_cnt    = int'($urandom_range(0, 6));
         if (!use_i && d_cnt == 0) d_cnt = 1;
         i_addr_r = $urandom & 32'hFFFF_FFFC;
         scram    = $urandom | 32'h4;
         for (int k = 0; k < d_cnt; k++)
            d_list[k] = {1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom)};
         test_round("random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lone_ifetch();
      test_starvation();
      test_contention();
      test_stability();
      test_protocol_err();
      test_reset_mid_op();
      test_random(40);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
